lampfpu_sqrt_issue: RTL and testbench

- Request-side initiator for the lampFPU square-root / inverse-square-root unit.
- Accepts a packed 16-bit float (1/8/7) over a valid/ready handshake and unpacks and classifies it.
- Holds the operand stable while the sqrt unit computes, captures the unit's result, and returns it packed over a response handshake.
- Adds a watchdog that returns an error if the sqrt unit never raises valid.

---
 rtl/lampFPU_pkg.sv | 58 +++++
 rtl/lampfpu_sqrt_issue_classify.sv | 24 ++
 rtl/lampfpu_sqrt_issue.sv | 167 ++++++++++++++++
 tb/tb_lampfpu_sqrt_issue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lampFPU_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lampFPU_pkg
//  Description : Shared lampFPU types, widths and helpers. Holds the packed
//                16-bit float (1/8/7) field widths, the canonical quiet NaN,
//                the sqrt-issue FSM state type and the operand
//                unpack/classify function.
//  Revision    : 1.0 - initial release
// ============================================================================
package lampFPU_pkg;

  localparam int LAMP_FLOAT_DW   = 16;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;

  // Exponent/fraction of the canonical quiet NaN (sign bit excluded).
  localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] QNAN_E_F = 15'h7FC0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sqrtIssueState_t;

  typedef struct packed {
    logic                       sign;
    logic [LAMP_FLOAT_E_DW-1:0] extExp;
    logic [LAMP_FLOAT_E_DW-1:0] extMant;  // {hidden bit, fraction}
    logic                       isInf;
    logic                       isZero;
    logic                       isSNAN;
    logic                       isQNAN;
  } opClass_t;

  // Unpacks a packed float and derives its class flags. With flush_denorm
  // set, any zero exponent is treated as a signed zero.
  function automatic opClass_t FUNC_unpackClassify(
    input logic [LAMP_FLOAT_DW-1:0] op,
    input logic                     flush_denorm
  );
    opClass_t                   c;
    logic [LAMP_FLOAT_E_DW-1:0] e;
    logic [LAMP_FLOAT_F_DW-1:0] f;
    e         = op[LAMP_FLOAT_DW-2:LAMP_FLOAT_F_DW];
    f         = op[LAMP_FLOAT_F_DW-1:0];
    c.sign    = op[LAMP_FLOAT_DW-1];
    c.extExp  = e;
    c.extMant = {|e, f};
    c.isZero  = (e == '0) && ((f == '0) || flush_denorm);
    c.isInf   = (e == '1) && (f == '0);
    c.isQNAN  = (e == '1) && f[LAMP_FLOAT_F_DW-1];
    c.isSNAN  = (e == '1) && (f != '0) && !f[LAMP_FLOAT_F_DW-1];
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lampfpu_sqrt_issue_classify.sv
`default_nettype none
// ============================================================================
//  Module      : lampfpu_sqrt_classify
//  Description : Purely combinational unpack/classify of a packed float
//                operand, feeding the operand registers of the issue stage.
//  Revision    : 1.0 - initial release
//  Ports       : op_i  - packed operand {s,e[7:0],f[6:0]}
//                cls_o - sign, extExp, extMant and class flags
// ============================================================================
module lampfpu_sqrt_classify
  import lampFPU_pkg::*;
#(
  parameter int FLUSH_DENORM = 1
) (
  input  logic [LAMP_FLOAT_DW-1:0] op_i,
  output opClass_t                 cls_o
);

  localparam logic c_FLUSH = (FLUSH_DENORM != 0);

  assign cls_o = FUNC_unpackClassify(op_i, c_FLUSH);

endmodule
`default_nettype wire

// File: rtl/lampfpu_sqrt_issue.sv
`default_nettype none
// ============================================================================
//  Module      : lampfpu_sqrt_issue
//  Description : Request-side initiator for the lampFPU sqrt / inverse-sqrt
//                unit. Accepts a packed operand, classifies it, holds it
//                stable for the sqrt unit, issues a one-cycle start pulse,
//                captures the result and returns it over a response
//                handshake. A watchdog returns the canonical QNAN with an
//                error flag if the unit never answers.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst (async, active-low)
//                req_*   - request handshake, operand and op select
//                *_op_o, doSqrt_o, invSqrt_o - interface to the sqrt unit
//                *_res_i, valid_i             - result from the sqrt unit
//                rsp_*   - response handshake, packed result, error flag
// ============================================================================
module lampfpu_sqrt_issue
  import lampFPU_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,  // at least 2
  parameter int FLUSH_DENORM   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  // request
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [LAMP_FLOAT_DW-1:0]   req_op_i,
  input  logic                       req_inv_i,
  // to sqrt unit
  output logic                       doSqrt_o,
  output logic                       invSqrt_o,
  output logic                       signum_op_o,
  output logic [LAMP_FLOAT_E_DW-1:0] extExp_op_o,
  output logic [LAMP_FLOAT_E_DW-1:0] extMant_op_o,
  output logic                       isInf_op_o,
  output logic                       isZero_op_o,
  output logic                       isSNAN_op_o,
  output logic                       isQNAN_op_o,
  // from sqrt unit
  input  logic                       s_res_i,
  input  logic [LAMP_FLOAT_E_DW-1:0] e_res_i,
  input  logic [LAMP_FLOAT_F_DW-1:0] f_res_i,
  input  logic                       valid_i,
  // response
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [LAMP_FLOAT_DW-1:0]   rsp_res_o,
  output logic                       rsp_err_o
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  sqrtIssueState_t          r_state;
  sqrtIssueState_t          w_state_nxt;
  opClass_t                 w_cls;
  opClass_t                 r_cls;
  logic                     r_inv;
  logic [c_CNT_W-1:0]       r_cnt;
  logic [c_CNT_W-1:0]       w_cnt_inc;
  logic [LAMP_FLOAT_DW-1:0] r_res;
  logic                     r_err;
  logic                     w_load;
  logic                     w_capture;
  logic                     w_timeout;

  lampfpu_sqrt_classify #(
    .FLUSH_DENORM (FLUSH_DENORM)
  ) u_classify (
    .op_i  (req_op_i),
    .cls_o (w_cls)
  );

  // Saturating increment; the timeout compares against the incremented
  // value so the response lands TIMEOUT_CYCLES+1 cycles after acceptance.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + c_CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    req_ready_o = 1'b0;
    doSqrt_o    = 1'b0;
    rsp_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        doSqrt_o = 1'b1;
        if (valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A result in the same cycle as the timeout takes priority.
        if (valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else if (w_cnt_inc == c_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cls   <= '0;
      r_inv   <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Operand stays put until the next acceptance: the sqrt unit keeps
      // sampling it after the start pulse.
      if (w_load) begin
        r_cls <= w_cls;
        r_inv <= req_inv_i;
      end
      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_capture) begin
        r_res <= {s_res_i, e_res_i, f_res_i};
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_res <= {1'b0, QNAN_E_F};
        r_err <= 1'b1;
      end
    end
  end

  assign invSqrt_o    = r_inv;
  assign signum_op_o  = r_cls.sign;
  assign extExp_op_o  = r_cls.extExp;
  assign extMant_op_o = r_cls.extMant;
  assign isInf_op_o   = r_cls.isInf;
  assign isZero_op_o  = r_cls.isZero;
  assign isSNAN_op_o  = r_cls.isSNAN;
  assign isQNAN_op_o  = r_cls.isQNAN;
  assign rsp_res_o    = r_res;
  assign rsp_err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lampfpu_sqrt_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lampfpu_sqrt_issue
//  Description : Self-checking bench for lampfpu_sqrt_issue with a
//                behavioural sqrt unit model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lampfpu_sqrt_issue;

  localparam int TMO = 8;
  localparam int LAT = 4;

  typedef struct packed {
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready_o;
  logic [15:0] req_op;
  logic        req_inv;
  logic        doSqrt_o, invSqrt_o, signum_op_o;
  logic [7:0]  extExp_op_o, extMant_op_o;
  logic        isInf_op_o, isZero_op_o, isSNAN_op_o, isQNAN_op_o;
  logic        valid_i;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [15:0] rsp_res_o;
  logic        rsp_err_o;

  logic        model_en     = 1'b1;
  logic        model_valid  = 1'b0;
  logic        manual_valid = 1'b0;
  logic [15:0] model_res    = 16'h0;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rsp_rise_cyc = 0;
  int   hs_cyc = 0;
  int   n_rsp = 0;
  logic prev_rsp = 1'b0;

  assign valid_i = model_valid | manual_valid;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lampfpu_sqrt_issue #(
    .TIMEOUT_CYCLES (TMO),
    .FLUSH_DENORM   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op),
    .req_inv_i    (req_inv),
    .doSqrt_o     (doSqrt_o),
    .invSqrt_o    (invSqrt_o),
    .signum_op_o  (signum_op_o),
    .extExp_op_o  (extExp_op_o),
    .extMant_op_o (extMant_op_o),
    .isInf_op_o   (isInf_op_o),
    .isZero_op_o  (isZero_op_o),
    .isSNAN_op_o  (isSNAN_op_o),
    .isQNAN_op_o  (isQNAN_op_o),
    .s_res_i      (model_res[15]),
    .e_res_i      (model_res[14:7]),
    .f_res_i      (model_res[6:0]),
    .valid_i      (valid_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_res_o    (rsp_res_o),
    .rsp_err_o    (rsp_err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact results for even-exponent powers of two, pass-through otherwise.
  function automatic logic [15:0] sqrt_ref(input logic s, input logic [7:0] e,
                                           input logic [7:0] m, input logic inv);
    int         unb;
    logic [7:0] eo;
    if (!s && m == 8'h80 && e != 8'h00 && e != 8'hFF && e[0]) begin
      unb = int'(e) - 127;
      eo  = inv ? 8'(127 - unb / 2) : 8'(127 + unb / 2);
      return {1'b0, eo, 7'h00};
    end
    return {s, e, m[6:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_req(input logic [15:0] op, input logic inv, input logic push,
                          input logic [15:0] res, input logic err);
    logic ok;
    if (push) sb_q.push_back('{res: res, err: err});
    req_op    = op;
    req_inv   = inv;
    req_valid = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        ok      = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq("req_accept", ok, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("drain", sb_q.size(), 0);
  endtask

  // Behavioural sqrt unit: answers LAT cycles after the start pulse.
  initial begin : sqrt_model
    logic       m_s, m_inv;
    logic [7:0] m_e, m_m;
    forever begin
      @(posedge clk);
      #1;
      if (doSqrt_o && model_en) begin
        m_s   = signum_op_o;
        m_e   = extExp_op_o;
        m_m   = extMant_op_o;
        m_inv = invSqrt_o;
        repeat (LAT) @(posedge clk);
        #1;
        model_res   = sqrt_ref(m_s, m_e, m_m, m_inv);
        model_valid = 1'b1;
        @(posedge clk);
        #1;
        model_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rsp_valid_o && !prev_rsp) begin
          rsp_rise_cyc = cyc;
          n_rsp++;
        end
        if (rsp_valid_o && rsp_ready) begin
          hs_cyc = cyc;
          if (sb_q.size() == 0) begin
            check_eq("rsp_unexpected", rsp_valid_o, 0);
          end else begin
            e = sb_q.pop_front();
            check_eq("rsp_res", rsp_res_o, e.res);
            check_eq("rsp_err", rsp_err_o, e.err);
          end
        end
      end
      prev_rsp = rsp_valid_o;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [15:0] cls_ops  [4] = '{16'h7F81, 16'h7FC0, 16'h0001, 16'h7F80};
    logic [3:0]  cls_flags[4] = '{4'b0010, 4'b0001, 4'b0100, 4'b1000}; // inf,zero,snan,qnan
    logic [7:0]  cls_mant [4] = '{8'h81, 8'hC0, 8'h01, 8'h80};
    logic        ok;
    int          rsp_before;

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_inv = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", req_ready_o, 1);
    check_eq("rst_rsp_valid", rsp_valid_o, 0);
    check_eq("rst_dosqrt", doSqrt_o, 0);
    check_eq("rst_rsp_res", rsp_res_o, 0);
    check_eq("rst_ext_mant", extMant_op_o, 0);
    rst_n = 1'b1;
    step();

    // sqrt(4.0)
    send_req(16'h4080, 1'b0, 1'b1, 16'h4000, 1'b0);
    @(negedge clk);
    check_eq("dosqrt_high", doSqrt_o, 1);
    check_eq("dosqrt_lat", cyc - acc_cyc, 1);
    check_eq("ext_exp", extExp_op_o, 8'h81);
    check_eq("ext_mant", extMant_op_o, 8'h80);
    @(negedge clk);
    check_eq("dosqrt_pulse", doSqrt_o, 0);
    wait_drain();
    check_eq("rsp_lat", rsp_rise_cyc - acc_cyc, 6);

    // inverse sqrt(4.0)
    send_req(16'h4080, 1'b1, 1'b1, 16'h3F00, 1'b0);
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!invSqrt_o) ok = 1'b0;
    end
    check_eq("inv_hold", ok, 1);
    wait_drain();
    check_eq("inv_after_rsp", invSqrt_o, 1);

    // classification table
    for (int i = 0; i < 4; i++) begin
      send_req(cls_ops[i], 1'b0, 1'b1, cls_ops[i], 1'b0);
      @(negedge clk);
      check_eq("class_flags", {isInf_op_o, isZero_op_o, isSNAN_op_o, isQNAN_op_o}, cls_flags[i]);
      check_eq("class_mant", extMant_op_o, cls_mant[i]);
      wait_drain();
    end

    // watchdog: the unit never answers
    model_en = 1'b0;
    send_req(16'h4080, 1'b0, 1'b1, 16'h7FC0, 1'b1);
    wait_drain();
    check_eq("tmo_lat", rsp_rise_cyc - acc_cyc, TMO + 1);
    model_en   = 1'b1;
    rsp_before = n_rsp;
    manual_valid = 1'b1;
    step();
    manual_valid = 1'b0;
    repeat (4) step();
    check_eq("late_valid_dropped", n_rsp, rsp_before);
    check_eq("late_valid_ready", req_ready_o, 1);

    // response back-pressure then back-to-back request
    rsp_ready = 1'b0;
    send_req(16'h4080, 1'b0, 1'b1, 16'h4000, 1'b0);
    for (int i = 0; i < 30 && !rsp_valid_o; i++) step();
    check_eq("bp_rsp_valid", rsp_valid_o, 1);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_res_o !== 16'h4000 || req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1) ok = 1'b0;
    end
    check_eq("bp_stable", ok, 1);
    step();
    rsp_ready = 1'b1;
    send_req(16'h4080, 1'b1, 1'b1, 16'h3F00, 1'b0);
    check_eq("b2b_accept", acc_cyc - hs_cyc, 1);
    wait_drain();

    // async reset during WAIT
    send_req(16'h4080, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_req_ready", req_ready_o, 1);
    check_eq("arst_outputs", {doSqrt_o, invSqrt_o, rsp_valid_o, rsp_err_o, signum_op_o,
                              isInf_op_o, isZero_op_o, isSNAN_op_o, isQNAN_op_o}, 0);
    check_eq("arst_ext", {extExp_op_o, extMant_op_o}, 0);
    check_eq("arst_rsp_res", rsp_res_o, 0);
    step();
    rst_n      = 1'b1;
    rsp_before = n_rsp;
    repeat (10) step();
    check_eq("arst_no_rsp", n_rsp, rsp_before);
    check_eq("arst_idle", req_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
